// File: rtl/ssd1331_spi_rx_if.sv
// Panel-side SSD1331 SPI lines plus the decoded command/pixel/status outputs.
// The receiver takes the slave view; a driver or bench takes the master view.
interface ssd1331_spi_rx_if;
  logic        oled_csn;
  logic        oled_clk;
  logic        oled_mosi;
  logic        oled_dc;
  logic        oled_resn;

  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        px_valid;
  logic [6:0]  px_x;
  logic [5:0]  px_y;
  logic [15:0] px_color;
  logic        display_on;
  logic [7:0]  data_format;

  modport master (
    output oled_csn, oled_clk, oled_mosi, oled_dc, oled_resn,
    input  cmd_valid, cmd_byte, px_valid, px_x, px_y, px_color, display_on, data_format
  );

  modport slave (
    input  oled_csn, oled_clk, oled_mosi, oled_dc, oled_resn,
    output cmd_valid, cmd_byte, px_valid, px_x, px_y, px_color, display_on, data_format
  );
endinterface

// File: rtl/ssd1331_spi_rx.sv
// SSD1331 SPI receiver: rebuilds bytes from the oled_* lines, decodes commands,
// tracks the address window and emits (x, y, color) strobes for every pixel written.
module ssd1331_spi_rx #(
  parameter int unsigned WIDTH       = 96,
  parameter int unsigned HEIGHT      = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              resn,
  ssd1331_spi_rx_if.slave  bus
);

  localparam logic [6:0] ColMax  = 7'(WIDTH - 1);
  localparam logic [5:0] RowMax  = 6'(HEIGHT - 1);
  // Bit order {resn, dc, mosi, sck, csn}; panel held in reset, chip deselected.
  localparam logic [4:0] SyncRst = 5'b00001;

  typedef enum logic [0:0] {StOpcode, StArgs} state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [4:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= SyncRst;
    end else begin
      sync_q[0] <= {bus.oled_resn, bus.oled_dc, bus.oled_mosi, bus.oled_clk, bus.oled_csn};
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic csn_s, sck_s, mosi_s, dc_s, soft_rst;
  assign csn_s    = sync_q[SYNC_STAGES-1][0];
  assign sck_s    = sync_q[SYNC_STAGES-1][1];
  assign mosi_s   = sync_q[SYNC_STAGES-1][2];
  assign dc_s     = sync_q[SYNC_STAGES-1][3];
  assign soft_rst = ~sync_q[SYNC_STAGES-1][4];

  // ---------------------------------------------------------------------------
  // Byte assembly
  // ---------------------------------------------------------------------------
  logic       sck_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic       byte_done_q;
  logic [7:0] byte_q;
  logic       byte_dc_q;
  logic       sck_rise;

  assign sck_rise = sck_s & ~sck_q;

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      sck_q       <= 1'b0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      byte_done_q <= 1'b0;
      byte_q      <= 8'd0;
      byte_dc_q   <= 1'b0;
    end else begin
      sck_q       <= sck_s;
      byte_done_q <= 1'b0;
      if (soft_rst) begin
        bit_cnt_q <= 3'd0;
      // The 8th edge still lands if csn rises on the same cycle.
      end else if (sck_rise && (!csn_s || bit_cnt_q == 3'd7)) begin
        shift_q   <= {shift_q[5:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_done_q <= 1'b1;
          byte_q      <= {shift_q, mosi_s};
          byte_dc_q   <= dc_s;
        end
      end else if (csn_s) begin
        bit_cnt_q <= 3'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command decode, window tracking and pixel emission
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] num_args(input logic [7:0] op);
    case (op)
      8'hA0, 8'hA1, 8'hA2, 8'hA8, 8'hAD, 8'hB0, 8'hB1, 8'hB3, 8'hBB, 8'hBE,
      8'h81, 8'h82, 8'h83, 8'h87, 8'h8A, 8'h8B, 8'h8C: num_args = 2'd1;
      8'h15, 8'h75:                                    num_args = 2'd2;
      default:                                         num_args = 2'd0;
    endcase
  endfunction

  function automatic logic [6:0] clamp_col(input logic [7:0] b);
    clamp_col = (b[6:0] > ColMax) ? ColMax : b[6:0];
  endfunction

  function automatic logic [5:0] clamp_row(input logic [7:0] b);
    clamp_row = (b[5:0] > RowMax) ? RowMax : b[5:0];
  endfunction

  state_e      state_q;
  logic [7:0]  op_q, arg0_q, hi_q;
  logic        arg_idx_q, half_q;
  logic [6:0]  col_q, col_start_q, col_end_q;
  logic [5:0]  row_q, row_start_q, row_end_q;
  logic        cmd_valid_q, px_valid_q, display_on_q;
  logic [7:0]  cmd_byte_q, data_format_q;
  logic [6:0]  px_x_q;
  logic [5:0]  px_y_q;
  logic [15:0] px_color_q;

  logic       col_wrap, row_wrap, mode8;
  logic [6:0] adv_col;
  logic [5:0] adv_row;

  assign col_wrap = (col_q == col_end_q) || (col_q == ColMax);
  assign row_wrap = (row_q == row_end_q) || (row_q == RowMax);
  assign mode8    = (data_format_q[7:6] == 2'b00);

  // Wrapping on the panel edge as well covers windows with start > end.
  always_comb begin
    adv_col = col_q;
    adv_row = row_q;
    if (!data_format_q[0]) begin
      if (col_wrap) begin
        adv_col = col_start_q;
        adv_row = row_wrap ? row_start_q : row_q + 6'd1;
      end else begin
        adv_col = col_q + 7'd1;
      end
    end else begin
      if (row_wrap) begin
        adv_row = row_start_q;
        adv_col = col_wrap ? col_start_q : col_q + 7'd1;
      end else begin
        adv_row = row_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_q       <= StOpcode;
      op_q          <= 8'd0;
      arg0_q        <= 8'd0;
      arg_idx_q     <= 1'b0;
      hi_q          <= 8'd0;
      half_q        <= 1'b0;
      col_q         <= 7'd0;
      row_q         <= 6'd0;
      col_start_q   <= 7'd0;
      col_end_q     <= ColMax;
      row_start_q   <= 6'd0;
      row_end_q     <= RowMax;
      cmd_valid_q   <= 1'b0;
      cmd_byte_q    <= 8'd0;
      px_valid_q    <= 1'b0;
      px_x_q        <= 7'd0;
      px_y_q        <= 6'd0;
      px_color_q    <= 16'd0;
      display_on_q  <= 1'b0;
      data_format_q <= 8'h40;
    end else if (soft_rst) begin
      state_q       <= StOpcode;
      arg_idx_q     <= 1'b0;
      half_q        <= 1'b0;
      col_q         <= 7'd0;
      row_q         <= 6'd0;
      col_start_q   <= 7'd0;
      col_end_q     <= ColMax;
      row_start_q   <= 6'd0;
      row_end_q     <= RowMax;
      cmd_valid_q   <= 1'b0;
      cmd_byte_q    <= 8'd0;
      px_valid_q    <= 1'b0;
      px_x_q        <= 7'd0;
      px_y_q        <= 6'd0;
      px_color_q    <= 16'd0;
      display_on_q  <= 1'b0;
      data_format_q <= 8'h40;
    end else begin
      cmd_valid_q <= 1'b0;
      px_valid_q  <= 1'b0;
      if (byte_done_q && !byte_dc_q) begin
        cmd_valid_q <= 1'b1;
        cmd_byte_q  <= byte_q;
        half_q      <= 1'b0;
        if (state_q == StOpcode) begin
          if (num_args(byte_q) == 2'd0) begin
            if (byte_q == 8'hAE) display_on_q <= 1'b0;
            if (byte_q == 8'hAF) display_on_q <= 1'b1;
          end else begin
            state_q   <= StArgs;
            op_q      <= byte_q;
            arg_idx_q <= 1'b0;
          end
        end else if (num_args(op_q) == 2'd2 && !arg_idx_q) begin
          arg0_q    <= byte_q;
          arg_idx_q <= 1'b1;
        end else begin
          state_q <= StOpcode;
          case (op_q)
            8'hA0: data_format_q <= byte_q;
            8'h15: begin
              col_start_q <= clamp_col(arg0_q);
              col_end_q   <= clamp_col(byte_q);
              col_q       <= clamp_col(arg0_q);
            end
            8'h75: begin
              row_start_q <= clamp_row(arg0_q);
              row_end_q   <= clamp_row(byte_q);
              row_q       <= clamp_row(arg0_q);
            end
            default: ;
          endcase
        end
      end else if (byte_done_q) begin
        // Pixel data aborts any command still waiting for arguments.
        state_q <= StOpcode;
        if (mode8 || half_q) begin
          px_valid_q <= 1'b1;
          px_x_q     <= data_format_q[1] ? ColMax - col_q : col_q;
          px_y_q     <= row_q;
          px_color_q <= mode8 ? {8'h00, byte_q} : {hi_q, byte_q};
          col_q      <= adv_col;
          row_q      <= adv_row;
          half_q     <= 1'b0;
        end else begin
          hi_q   <= byte_q;
          half_q <= 1'b1;
        end
      end
    end
  end

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_byte    = cmd_byte_q;
  assign bus.px_valid    = px_valid_q;
  assign bus.px_x        = px_x_q;
  assign bus.px_y        = px_y_q;
  assign bus.px_color    = px_color_q;
  assign bus.display_on  = display_on_q;
  assign bus.data_format = data_format_q;

endmodule

// File: tb/tb_ssd1331_spi_rx.sv
// Directed bench for ssd1331_spi_rx: drives SPI bytes and checks decoded strobes
// against hand-computed expectations.
module tb_ssd1331_spi_rx;

  logic clk  = 1'b0;
  logic resn = 1'b0;
  int   cyc  = 0;
  int   checks = 0;
  int   failures = 0;
  int   cmd_cnt = 0;
  int   cmd_cyc = 0;
  int   rise_cyc = 0;
  logic [6:0]  lx [$];
  logic [5:0]  ly [$];
  logic [15:0] lc [$];

  ssd1331_spi_rx_if bus ();

  ssd1331_spi_rx #(.WIDTH(96), .HEIGHT(64), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .resn (resn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.cmd_valid) begin
      cmd_cnt++;
      cmd_cyc = cyc;
    end
    if (bus.px_valid) begin
      lx.push_back(bus.px_x);
      ly.push_back(bus.px_y);
      lc.push_back(bus.px_color);
    end
  end

  localparam logic [7:0] InitSeq [44] = '{
    8'hBC, 8'hAE, 8'hA0, 8'h22, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA8, 8'h3F, 8'hAD,
    8'h8E, 8'hB0, 8'h0B, 8'hB1, 8'h31, 8'hB3, 8'hF0, 8'h8A, 8'h64, 8'h8B, 8'h78,
    8'h8C, 8'h64, 8'hBB, 8'h3A, 8'hBE, 8'h3E, 8'h87, 8'h06, 8'h81, 8'h91, 8'h82,
    8'h50, 8'h83, 8'h7D, 8'h2E, 8'h15, 8'h00, 8'h5F, 8'h75, 8'h00, 8'h3F, 8'hAF};

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_px(input string tag, input int idx, input logic [6:0] x,
                        input logic [5:0] y, input logic [15:0] c);
    check({tag, "_present"}, 32'(lx.size() > idx), 32'd1);
    if (lx.size() > idx) begin
      check({tag, "_x"}, 32'(lx[idx]), 32'(x));
      check({tag, "_y"}, 32'(ly[idx]), 32'(y));
      check({tag, "_color"}, 32'(lc[idx]), 32'(c));
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i >= 8 - n; i--) begin
      bus.oled_mosi = b[i];
      tick(2);
      bus.oled_clk = 1'b1;
      if (i == 0) rise_cyc = cyc;
      tick(2);
      bus.oled_clk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    bus.oled_dc = dc;
    send_bits(b, 8);
    tick(4);
  endtask

  int base;
  int cbase;

  initial begin
    bus.oled_csn  = 1'b1;
    bus.oled_clk  = 1'b0;
    bus.oled_mosi = 1'b0;
    bus.oled_dc   = 1'b0;
    bus.oled_resn = 1'b1;
    tick(3);
    @(negedge clk);
    check("rst_data_format", 32'(bus.data_format), 32'h40);
    check("rst_display_on", 32'(bus.display_on), 32'd0);
    check("rst_px_x", 32'(bus.px_x), 32'd0);
    check("rst_px_color", 32'(bus.px_color), 32'd0);
    check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    resn = 1'b1;
    tick(3);
    bus.oled_csn = 1'b0;
    tick(4);

    // Init sequence
    for (int i = 0; i < 44; i++) send_byte(InitSeq[i], 1'b0);
    check("init_cmd_count", 32'(cmd_cnt), 32'd44);
    check("init_last_cmd", 32'(bus.cmd_byte), 32'hAF);
    check("init_data_format", 32'(bus.data_format), 32'h22);
    check("init_display_on", 32'(bus.display_on), 32'd1);
    check("init_px_count", 32'(lx.size()), 32'd0);

    // Full-width row with column remap, then wrap to next row
    for (int i = 0; i < 97; i++) send_byte(8'(i), 1'b1);
    chk_px("row_first", 0, 7'd95, 6'd0, 16'h0000);
    chk_px("row_96th", 95, 7'd0, 6'd0, 16'h005F);
    chk_px("row_wrap", 96, 7'd95, 6'd1, 16'h0060);

    // 3x2 window, 8-bit, no remap
    send_byte(8'h15, 1'b0); send_byte(8'h0A, 1'b0); send_byte(8'h0C, 1'b0);
    send_byte(8'h75, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h06, 1'b0);
    send_byte(8'hA0, 1'b0); send_byte(8'h00, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i), 1'b1);
    chk_px("win0", 97, 7'd10, 6'd5, 16'h0010);
    chk_px("win1", 98, 7'd11, 6'd5, 16'h0011);
    chk_px("win2", 99, 7'd12, 6'd5, 16'h0012);
    chk_px("win3", 100, 7'd10, 6'd6, 16'h0013);
    chk_px("win4", 101, 7'd11, 6'd6, 16'h0014);
    chk_px("win5", 102, 7'd12, 6'd6, 16'h0015);

    // 16-bit mode
    send_byte(8'hA0, 1'b0); send_byte(8'h40, 1'b0);
    send_byte(8'hF8, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h07, 1'b1); send_byte(8'hE0, 1'b1);
    chk_px("rgb0", 103, 7'd10, 6'd5, 16'hF800);
    chk_px("rgb1", 104, 7'd11, 6'd5, 16'h07E0);
    send_byte(8'h12, 1'b1);
    check("odd_byte_no_px", 32'(lx.size()), 32'd105);

    // Command aborted by a data byte
    send_byte(8'hA0, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h15, 1'b0); send_byte(8'h10, 1'b0);
    send_byte(8'h33, 1'b1);
    chk_px("abort_px", 105, 7'd12, 6'd5, 16'h0033);
    send_byte(8'hAE, 1'b0);
    check("abort_then_ae", 32'(bus.display_on), 32'd0);
    send_byte(8'h44, 1'b1);
    chk_px("abort_window_kept", 106, 7'd10, 6'd6, 16'h0044);

    // Partial byte discarded by csn high
    cbase = cmd_cnt;
    bus.oled_dc = 1'b0;
    send_bits(8'hFF, 5);
    bus.oled_csn = 1'b1;
    tick(4);
    bus.oled_csn = 1'b0;
    tick(4);
    send_byte(8'hAF, 1'b0);
    check("csn_abort_count", 32'(cmd_cnt - cbase), 32'd1);
    check("csn_abort_byte", 32'(bus.cmd_byte), 32'hAF);
    check("csn_abort_display", 32'(bus.display_on), 32'd1);
    check("strobe_latency", 32'(cmd_cyc - rise_cyc), 32'd4);

    // Clamped window at the panel corner
    send_byte(8'h15, 1'b0); send_byte(8'h7F, 1'b0); send_byte(8'h70, 1'b0);
    send_byte(8'h75, 1'b0); send_byte(8'h3E, 1'b0); send_byte(8'h3F, 1'b0);
    for (int i = 1; i <= 3; i++) send_byte(8'(i), 1'b1);
    chk_px("clamp0", 107, 7'd95, 6'd62, 16'h0001);
    chk_px("clamp1", 108, 7'd95, 6'd63, 16'h0002);
    chk_px("clamp2", 109, 7'd95, 6'd62, 16'h0003);

    // Vertical increment, column start > end wraps at the panel edge
    send_byte(8'hA0, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h15, 1'b0); send_byte(8'h5E, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h75, 1'b0); send_byte(8'h3E, 1'b0); send_byte(8'h3F, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 1'b1);
    chk_px("vert0", 110, 7'd94, 6'd62, 16'h00C0);
    chk_px("vert1", 111, 7'd94, 6'd63, 16'h00C1);
    chk_px("vert2", 112, 7'd95, 6'd62, 16'h00C2);
    chk_px("vert3", 113, 7'd95, 6'd63, 16'h00C3);
    chk_px("vert4", 114, 7'd94, 6'd62, 16'h00C4);

    // Async reset in the middle of a byte
    bus.oled_dc = 1'b0;
    send_bits(8'hA5, 5);
    #2 resn = 1'b0;
    @(negedge clk);
    check("mid_rst_data_format", 32'(bus.data_format), 32'h40);
    check("mid_rst_display_on", 32'(bus.display_on), 32'd0);
    check("mid_rst_px_x", 32'(bus.px_x), 32'd0);
    check("mid_rst_px_color", 32'(bus.px_color), 32'd0);
    tick(2);
    resn = 1'b1;
    tick(6);
    cbase = cmd_cnt;
    send_byte(8'hAF, 1'b0);
    check("post_rst_count", 32'(cmd_cnt - cbase), 32'd1);
    check("post_rst_byte", 32'(bus.cmd_byte), 32'hAF);
    check("post_rst_display", 32'(bus.display_on), 32'd1);

    // Panel reset line
    send_byte(8'hA0, 1'b0); send_byte(8'h72, 1'b0);
    check("df_before_panel_rst", 32'(bus.data_format), 32'h72);
    bus.oled_resn = 1'b0;
    tick(4);
    check("panel_rst_data_format", 32'(bus.data_format), 32'h40);
    check("panel_rst_display_on", 32'(bus.display_on), 32'd0);
    bus.oled_resn = 1'b1;
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
